// File: rtl/conv_ctrl_pkg.sv
// Shared types and default geometry for the convolution sequencing controller.
package conv_ctrl_pkg;

  localparam int CC_N       = 64;
  localparam int CC_M       = 33;
  localparam int CC_RD_LAT  = 1;
  localparam int CC_NOUT    = CC_N - CC_M + 1;
  localparam int CC_OUT_LAT = CC_M + CC_RD_LAT + 1;

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_OUTPUT  = 2'd3
  } ctrl_state_e;

endpackage

// File: rtl/conv_ctrl_delay.sv
// Fixed-depth shift register that aligns issue flags with operands leaving the memories.
module conv_ctrl_delay #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_r [DEPTH];

  // Shift the flags one stage per cycle; reset flushes every stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_r[i] <= '0;
      end
    end else begin
      stage_r[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end
  end

  assign dout = stage_r[DEPTH-1];

endmodule

// File: rtl/conv_ctrl_64_33.sv
// Sequencing controller for a 64-input, 33-tap convolution datapath: loads x,
// walks k/m through every output's MAC sequence and hands each y downstream.
module conv_ctrl_64_33
  import conv_ctrl_pkg::*;
#(
  parameter int N      = CC_N,
  parameter int M      = CC_M,
  parameter int RD_LAT = CC_RD_LAT,
  parameter int AW     = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          s_valid_x,
  output logic          s_ready_x,
  output logic          m_valid_y,
  input  logic          m_ready_y,
  output logic          wr_en_x,
  output logic [AW-1:0] addr_x,
  output logic [AW-1:0] addr_f,
  output logic          clear_acc,
  output logic          en_acc,
  output logic          ld_y
);

  ctrl_state_e   state_r, state_s;
  logic [AW-1:0] load_cnt_r, load_cnt_s;
  logic [AW-1:0] k_r, k_s;
  logic [AW-1:0] m_r, m_s;
  logic [AW-1:0] addr_x_hold_r, addr_f_hold_r;
  logic          issue_s, first_s;
  logic [1:0]    pipe_out_s;

  // State, counters and address hold registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= ST_LOAD;
      load_cnt_r    <= '0;
      k_r           <= '0;
      m_r           <= '0;
      addr_x_hold_r <= '0;
      addr_f_hold_r <= '0;
    end else begin
      state_r       <= state_s;
      load_cnt_r    <= load_cnt_s;
      k_r           <= k_s;
      m_r           <= m_s;
      addr_x_hold_r <= addr_x;
      addr_f_hold_r <= addr_f;
    end
  end

  // Next-state, counter updates and per-cycle control decode.
  always_comb begin
    state_s    = state_r;
    load_cnt_s = load_cnt_r;
    k_s        = k_r;
    m_s        = m_r;
    issue_s    = 1'b0;
    first_s    = 1'b0;
    wr_en_x    = 1'b0;
    ld_y       = 1'b0;
    addr_x     = addr_x_hold_r;
    addr_f     = addr_f_hold_r;
    case (state_r)
      ST_LOAD: begin
        addr_x  = load_cnt_r;
        wr_en_x = s_valid_x;
        if (s_valid_x) begin
          if (load_cnt_r == AW'(N - 1)) begin
            state_s    = ST_COMPUTE;
            load_cnt_s = '0;
            k_s        = '0;
            m_s        = '0;
          end else begin
            load_cnt_s = load_cnt_r + AW'(1);
          end
        end else begin
          load_cnt_s = load_cnt_r;
        end
      end
      ST_COMPUTE: begin
        issue_s = 1'b1;
        first_s = (m_r == '0);
        addr_x  = k_r + m_r;
        addr_f  = m_r;
        if (m_r == AW'(M - 1)) begin
          state_s = ST_DRAIN;
          m_s     = '0;
        end else begin
          m_s = m_r + AW'(1);
        end
      end
      ST_DRAIN: begin
        // m doubles as the drain counter; the last tap's update lands this cycle.
        if (m_r == AW'(RD_LAT - 1)) begin
          ld_y    = 1'b1;
          state_s = ST_OUTPUT;
          m_s     = '0;
        end else begin
          m_s = m_r + AW'(1);
        end
      end
      ST_OUTPUT: begin
        if (m_ready_y) begin
          if (k_r == AW'(N - M)) begin
            state_s = ST_LOAD;
            k_s     = '0;
          end else begin
            state_s = ST_COMPUTE;
            k_s     = k_r + AW'(1);
          end
        end else begin
          state_s = ST_OUTPUT;
        end
      end
      default: begin
        state_s = ST_LOAD;
      end
    endcase
  end

  assign s_ready_x = (state_r == ST_LOAD);
  assign m_valid_y = (state_r == ST_OUTPUT);

  conv_ctrl_delay #(
    .DEPTH (RD_LAT),
    .WIDTH (2)
  ) u_delay (
    .clk   (clk),
    .reset (reset),
    .din   ({issue_s, first_s}),
    .dout  (pipe_out_s)
  );

  assign en_acc    = pipe_out_s[1];
  assign clear_acc = pipe_out_s[1] & pipe_out_s[0];

endmodule

// File: tb/tb_conv_ctrl_64_33.sv
// Self-checking bench: a cycle-schedule model of load/compute/output timing
// is compared against the controller every cycle, plus literal timing pins.
module tb_conv_ctrl_64_33;

  localparam int N      = 64;
  localparam int M      = 33;
  localparam int RD_LAT = 1;
  localparam int AW     = 6;
  localparam int NOUT   = N - M + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          s_valid_x, s_ready_x, m_valid_y, m_ready_y;
  logic          wr_en_x, clear_acc, en_acc, ld_y;
  logic [AW-1:0] addr_x, addr_f;

  int checks = 0;
  int errors = 0;

  // Model state: either loading (mdl_cnt words taken) or on output mdl_k at
  // cycle mdl_t counted from the first issue of that output.
  bit mdl_loading = 1'b1;
  int mdl_cnt = 0, mdl_k = 0, mdl_t = 0;
  int cyc = 0, e0_cyc = 0, first_acc_cyc = 0, last_rise_cyc = -1000;
  int en_cnt = 0;
  bit pin_timing = 1'b0;
  logic prev_mv = 1'b0, prev_sr = 1'b1;

  conv_ctrl_64_33 dut (
    .clk       (clk),
    .reset     (reset),
    .s_valid_x (s_valid_x),
    .s_ready_x (s_ready_x),
    .m_valid_y (m_valid_y),
    .m_ready_y (m_ready_y),
    .wr_en_x   (wr_en_x),
    .addr_x    (addr_x),
    .addr_f    (addr_f),
    .clear_acc (clear_acc),
    .en_acc    (en_acc),
    .ld_y      (ld_y)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int exp_addr_x();
    if (mdl_loading) return mdl_cnt;
    else if (mdl_t < M) return mdl_k + mdl_t;
    else return mdl_k + M - 1;
  endfunction

  function automatic int exp_addr_f();
    if (mdl_t < M) return mdl_t;
    else return M - 1;
  endfunction

  function automatic int exp_en();
    return (!mdl_loading && mdl_t >= RD_LAT && mdl_t < M + RD_LAT) ? 1 : 0;
  endfunction

  // Schedule model: advances on each clock edge, resets asynchronously.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mdl_loading <= 1'b1;
      mdl_cnt     <= 0;
      mdl_k       <= 0;
      mdl_t       <= 0;
    end else begin
      cyc <= cyc + 1;
      if (mdl_loading) begin
        if (s_valid_x) begin
          if (mdl_cnt == 0) first_acc_cyc <= cyc + 1;
          if (mdl_cnt == N - 1) begin
            mdl_loading <= 1'b0;
            mdl_k       <= 0;
            mdl_t       <= 0;
            e0_cyc      <= cyc + 1;
          end else begin
            mdl_cnt <= mdl_cnt + 1;
          end
        end
      end else if (mdl_t < M + RD_LAT) begin
        mdl_t <= mdl_t + 1;
      end else if (m_ready_y) begin
        if (mdl_k == NOUT - 1) begin
          mdl_loading <= 1'b1;
          mdl_cnt     <= 0;
        end else begin
          mdl_k <= mdl_k + 1;
          mdl_t <= 0;
        end
      end
    end
  end

  // Compare every cycle on the falling edge, away from the active edge.
  always @(negedge clk) begin
    check("s_ready_x", s_ready_x, mdl_loading ? 1 : 0);
    check("m_valid_y", m_valid_y, (!mdl_loading && mdl_t >= M + RD_LAT) ? 1 : 0);
    check("wr_en_x", wr_en_x, mdl_loading ? int'(s_valid_x) : 0);
    check("addr_x", addr_x, exp_addr_x());
    if (!mdl_loading) check("addr_f", addr_f, exp_addr_f());
    check("en_acc", en_acc, exp_en());
    check("clear_acc", clear_acc, (!mdl_loading && mdl_t == RD_LAT) ? 1 : 0);
    check("ld_y", ld_y, (!mdl_loading && mdl_t == M + RD_LAT - 1) ? 1 : 0);
    if (ld_y) check("en_per_output", en_cnt + int'(en_acc), 33);
    en_cnt <= (reset || ld_y) ? 0 : en_cnt + int'(en_acc);
    if (pin_timing && !mdl_loading && cyc == e0_cyc + 1)
      check("first_clear", clear_acc & en_acc, 1);
    if (m_valid_y && !prev_mv) begin
      if (pin_timing && last_rise_cyc < e0_cyc) check("mvalid_latency", cyc - e0_cyc, 34);
      else if (pin_timing) check("out_period", cyc - last_rise_cyc, 35);
      last_rise_cyc <= cyc;
    end
    if (pin_timing && s_ready_x && !prev_sr)
      check("vector_cycles", cyc - first_acc_cyc + 1, 64 + 32 * 35);
    prev_mv <= m_valid_y;
    prev_sr <= s_ready_x;
  end

  // Load and compute one vector; gap/ready_mode select stall patterns.
  // A non-negative stop_k stops mid-compute at model (stop_k, stop_t).
  task automatic run_vector(input int gap, input int ready_mode, input int stop_k, input int stop_t);
    bit started = 1'b0;
    bit done = 1'b0;
    int wcnt = 0;
    for (int i = 0; i < 4000 && !done; i++) begin
      @(posedge clk);
      #1;
      if (!mdl_loading) started = 1'b1;
      if (started && mdl_loading) done = 1'b1;
      else if (stop_k >= 0 && !mdl_loading && mdl_k == stop_k && mdl_t == stop_t) done = 1'b1;
      else begin
        if (!mdl_loading && mdl_t >= M + RD_LAT) wcnt++;
        else wcnt = 0;
        if (gap != 0) s_valid_x = ((i % 4) != 3);
        else s_valid_x = mdl_loading;
        if (ready_mode == 0) m_ready_y = 1'b1;
        else if (!mdl_loading && mdl_k == 0) m_ready_y = (wcnt >= 10);
        else m_ready_y = ((i % 5) < 2);
      end
    end
    s_valid_x = 1'b0;
    m_ready_y = 1'b0;
    if (!done) begin
      errors++;
      $display("FAIL run_vector_timeout: got no completion expected completion within 4000 cycles");
    end
  endtask

  initial begin
    reset     = 1'b1;
    s_valid_x = 1'b0;
    m_ready_y = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("idle_s_ready", s_ready_x, 1);
    check("idle_m_valid", m_valid_y, 0);

    pin_timing = 1'b1;
    run_vector(0, 0, -1, -1);
    @(negedge clk);
    #1 pin_timing = 1'b0;

    run_vector(1, 1, -1, -1);

    run_vector(0, 0, 5, 17);
    check("mid_addr_x", addr_x, 22);
    check("mid_addr_f", addr_f, 17);
    reset = 1'b1;
    #1;
    check("rst_s_ready", s_ready_x, 1);
    check("rst_en_acc", en_acc, 0);
    check("rst_m_valid", m_valid_y, 0);
    check("rst_addr_x", addr_x, 0);
    @(posedge clk);
    #1 reset = 1'b0;

    run_vector(0, 0, -1, -1);
    repeat (3) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
